// File: rtl/lpca_pkg.sv
// Shared types, arithmetic constants and saturation helpers for lpc_analyzer.
package lpca_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDrain,
        StOut
    } lpca_state_e;

    localparam int unsigned ACC_W     = 40;
    localparam int unsigned OUT_SHIFT = 7;
    localparam int unsigned PIPE_LAT  = 3;

    localparam int          PREEMPH_MUL   = 15;
    localparam int          PREEMPH_SHIFT = 4;
    // 15 * x fits 21 signed bits, as does x - (15 * x_prev >>> 4).
    localparam int unsigned PE_W          = 21;

    function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] val);
        if (val[ACC_W-1:31] == '0 || val[ACC_W-1:31] == '1) begin
            return val[31:0];
        end else if (val[ACC_W-1]) begin
            return 32'sh8000_0000;
        end else begin
            return 32'sh7FFF_FFFF;
        end
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [PE_W-1:0] val);
        if (val[PE_W-1:15] == '0 || val[PE_W-1:15] == '1) begin
            return val[15:0];
        end else if (val[PE_W-1]) begin
            return 16'sh8000;
        end else begin
            return 16'sh7FFF;
        end
    endfunction

endpackage

// File: rtl/lpca_frame_buf.sv
// Ping-pong sample RAM: writes land in bank sel, both registered read ports see the other bank.
module lpca_frame_buf #(
    parameter int unsigned FRAME_LEN = 160,
    parameter int unsigned AW        = 8
) (
    input  logic                 clk,
    input  logic                 sel,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [15:0]   wdata,
    input  logic [AW-1:0]        raddr_a,
    input  logic [AW-1:0]        raddr_b,
    output logic signed [15:0]   rdata_a,
    output logic signed [15:0]   rdata_b
);

    logic signed [15:0] bank0 [FRAME_LEN];
    logic signed [15:0] bank1 [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (we && !sel) begin
            bank0[waddr] <= wdata;
        end
        if (we && sel) begin
            bank1[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_a <= sel ? bank0[raddr_a] : bank1[raddr_a];
        rdata_b <= sel ? bank0[raddr_b] : bank1[raddr_b];
    end

endmodule

// File: rtl/lpc_analyzer.sv
// LPC front end: ping-pong capture, autocorrelation R[0..ORDER] via one MAC, voicing decision.
// Define LPCA_PREEMPH_EN to pre-emphasize samples before storage and zero-crossing counting.
module lpc_analyzer
    import lpca_pkg::*;
#(
    parameter int unsigned FRAME_LEN     = 160,
    parameter int unsigned ORDER         = 10,
    parameter int unsigned ZC_THRESH     = 40,
    parameter int          ENERGY_THRESH = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v,
    input  logic signed [15:0]  x,
    output logic signed [31:0]  rout,
    output logic [3:0]          ridx,
    output logic                rvalid,
    input  logic                rready,
    output logic                rlast,
    output logic                voiced,
    output logic [8:0]          zc,
    output logic                busy,
    output logic                ovf
);

    localparam int unsigned AW = $clog2(FRAME_LEN);

    lpca_state_e state_q, state_d;

    logic [AW-1:0]          n_q, n_d;
    logic [3:0]             lag_q, lag_d;
    logic [1:0]             drain_q, drain_d;
    logic                   issue, acc_clr, load_out, accept;

    logic [AW-1:0]          wr_addr_q;
    logic                   cap_bank_q;
    logic [8:0]             zc_cnt_q, zc_next, zc_q;
    logic                   prev_sign_q;
    logic signed [15:0]     y;
    logic                   frame_end, handoff, drop;

    logic                   rd_v_q, prod_v_q;
    logic signed [15:0]     rd_a, rd_b;
    logic signed [31:0]     prod_q;
    logic signed [ACC_W-1:0] acc_q, acc_shift;
    logic signed [31:0]     r_sat;

    logic signed [31:0]     rout_q;
    logic [3:0]             ridx_q;
    logic                   rvalid_q, rlast_q, voiced_q, ovf_q;

`ifdef LPCA_PREEMPH_EN
    logic signed [15:0]     x_prev_q;
    logic signed [PE_W-1:0] pe_x, pe_sub, pe_diff;

    always_comb begin
        pe_x    = PE_W'(x);
        pe_sub  = (PE_W'(x_prev_q) * PE_W'(PREEMPH_MUL)) >>> PREEMPH_SHIFT;
        pe_diff = pe_x - pe_sub;
        y       = sat16(pe_diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_prev_q <= '0;
        end else if (v) begin
            x_prev_q <= x;
        end
    end
`else
    assign y = x;
`endif

    // Capture side never stalls; a completed frame is only handed over when analysis is idle.
    assign frame_end = (wr_addr_q == AW'(FRAME_LEN - 1));
    assign handoff   = v && frame_end && (state_q == StIdle);
    assign drop      = v && frame_end && (state_q != StIdle);
    assign zc_next   = (wr_addr_q == '0) ? '0 : zc_cnt_q + 9'(y[15] ^ prev_sign_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q   <= '0;
            cap_bank_q  <= 1'b0;
            zc_cnt_q    <= '0;
            prev_sign_q <= 1'b0;
            zc_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= drop;
            if (v) begin
                wr_addr_q   <= frame_end ? '0 : wr_addr_q + AW'(1);
                zc_cnt_q    <= zc_next;
                prev_sign_q <= y[15];
                if (handoff) begin
                    cap_bank_q <= ~cap_bank_q;
                    zc_q       <= zc_next;
                end
            end
        end
    end

    lpca_frame_buf #(
        .FRAME_LEN (FRAME_LEN),
        .AW        (AW)
    ) u_frame_buf (
        .clk     (clk),
        .sel     (cap_bank_q),
        .we      (v),
        .waddr   (wr_addr_q),
        .wdata   (y),
        .raddr_a (n_q),
        .raddr_b (n_q - AW'(lag_q)),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign accept = rvalid_q && rready;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        lag_d    = lag_q;
        drain_d  = drain_q;
        issue    = 1'b0;
        acc_clr  = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handoff) begin
                    state_d = StMac;
                    lag_d   = '0;
                    n_d     = '0;
                    acc_clr = 1'b1;
                end
            end
            StMac: begin
                issue = 1'b1;
                if (n_q == AW'(FRAME_LEN - 1)) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    n_d = n_q + AW'(1);
                end
            end
            StDrain: begin
                if (drain_q == 2'(PIPE_LAT - 1)) begin
                    state_d  = StOut;
                    load_out = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StOut: begin
                if (accept) begin
                    if (lag_q == 4'(ORDER)) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StMac;
                        lag_d   = lag_q + 4'd1;
                        n_d     = AW'(lag_q) + AW'(1);
                        acc_clr = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign acc_shift = acc_q >>> OUT_SHIFT;
    assign r_sat     = sat32(acc_shift);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            n_q      <= '0;
            lag_q    <= '0;
            drain_q  <= '0;
            rd_v_q   <= 1'b0;
            prod_v_q <= 1'b0;
            prod_q   <= '0;
            acc_q    <= '0;
            rout_q   <= '0;
            ridx_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            voiced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            lag_q    <= lag_d;
            drain_q  <= drain_d;
            rd_v_q   <= issue;
            prod_v_q <= rd_v_q;
            if (rd_v_q) begin
                prod_q <= 32'(rd_a) * 32'(rd_b);
            end
            if (acc_clr) begin
                acc_q <= '0;
            end else if (prod_v_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
            if (load_out) begin
                rout_q   <= r_sat;
                ridx_q   <= lag_q;
                rlast_q  <= (lag_q == 4'(ORDER));
                rvalid_q <= 1'b1;
                if (lag_q == '0) begin
                    voiced_q <= ({23'd0, zc_q} < ZC_THRESH) && (r_sat > ENERGY_THRESH);
                end
            end else if (accept) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign rout   = rout_q;
    assign ridx   = ridx_q;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign voiced = voiced_q;
    assign zc     = zc_q;
    assign busy   = (state_q != StIdle);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_lpc_analyzer.sv
// Randomized self-checking bench for lpc_analyzer against a sum-of-products reference model.
module tb_lpc_analyzer;

    localparam int FL  = 16;
    localparam int ORD = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v = 1'b0;
    logic rready = 1'b0;
    logic signed [15:0] x = '0;

    logic signed [31:0] rout, z_rout, b_rout;
    logic [3:0]         ridx, z_ridx, b_ridx;
    logic               rvalid, rlast, voiced, busy, ovf;
    logic               z_rvalid, z_rlast, z_voiced, z_busy, z_ovf;
    logic               b_rvalid, b_rlast, b_voiced, b_busy, b_ovf;
    logic [8:0]         zc, z_zc, b_zc;

    int     errors = 0;
    int     checks = 0;
    int     ovf_cnt = 0;
    int     st [256];
    longint exp_r [ORD+1];
    int     exp_zc;
    bit     exp_voiced, exp_voiced8;
`ifdef LPCA_PREEMPH_EN
    int     pe_prev = 0;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) if (ovf) ovf_cnt++;

    lpc_analyzer #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .v(v), .x(x), .rout(rout), .ridx(ridx), .rvalid(rvalid),
        .rready(rready), .rlast(rlast), .voiced(voiced), .zc(zc), .busy(busy), .ovf(ovf)
    );

    lpc_analyzer #(.FRAME_LEN(FL), .ZC_THRESH(8)) dut_zc8 (
        .clk(clk), .rst(rst), .v(v), .x(x), .rout(z_rout), .ridx(z_ridx), .rvalid(z_rvalid),
        .rready(rready), .rlast(z_rlast), .voiced(z_voiced), .zc(z_zc), .busy(z_busy),
        .ovf(z_ovf)
    );

    lpc_analyzer #(.FRAME_LEN(256)) dut_big (
        .clk(clk), .rst(rst), .v(v), .x(x), .rout(b_rout), .ridx(b_ridx), .rvalid(b_rvalid),
        .rready(rready), .rlast(b_rlast), .voiced(b_voiced), .zc(b_zc), .busy(b_busy),
        .ovf(b_ovf)
    );

    task automatic do_reset();
        rst = 1'b0;
        v = 1'b0;
        rready = 1'b0;
`ifdef LPCA_PREEMPH_EN
        pe_prev = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive_samples(input int n, input int mode, input int amp);
        for (int i = 0; i < n; i++) begin
            int raw;
            int y;
            case (mode)
                0:       raw = amp;
                1:       raw = (i % 2 == 0) ? amp : -amp;
                default: raw = int'($urandom_range(0, 2 * amp)) - amp;
            endcase
`ifdef LPCA_PREEMPH_EN
            y = raw - ((15 * pe_prev) >>> 4);
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            pe_prev = raw;
`else
            y = raw;
`endif
            st[i] = y;
            @(posedge clk);
            #1;
            v = 1'b1;
            x = 16'(raw);
        end
    endtask

    task automatic end_samples();
        @(posedge clk);
        #1;
        v = 1'b0;
    endtask

    task automatic compute_model(input int f);
        longint acc;
        int zc_n;
        zc_n = 0;
        for (int l = 0; l <= ORD; l++) begin
            acc = 0;
            for (int n = l; n < f; n++) acc += longint'(st[n]) * longint'(st[n-l]);
            acc = acc >>> 7;
            if (acc > 2147483647) acc = 2147483647;
            else if (acc < longint'(-2147483647) - 1) acc = longint'(-2147483647) - 1;
            exp_r[l] = acc;
        end
        for (int n = 1; n < f; n++) if ((st[n] < 0) != (st[n-1] < 0)) zc_n++;
        exp_zc = zc_n;
        exp_voiced  = (zc_n < 40) && (exp_r[0] > 1024);
        exp_voiced8 = (zc_n < 8) && (exp_r[0] > 1024);
    endtask

    // Collects lags [first, stop) from dut and compares each against the model.
    task automatic check_frame(input string tag, input int first, input int stop,
                               input bit rand_rdy);
        int lag;
        int guard;
        lag = first;
        guard = 0;
        while (lag < stop && guard < 3000) begin
            @(posedge clk);
            #1;
            rready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            guard++;
            if (rvalid && rready) begin
                checks++;
                if (rout !== 32'(exp_r[lag])) begin
                    errors++;
                    $display("FAIL %s rout lag %0d: got %0d expected %0d", tag, lag, rout,
                             exp_r[lag]);
                end
                checks++;
                if (ridx !== 4'(lag) || rlast !== 1'(lag == ORD)) begin
                    errors++;
                    $display("FAIL %s ridx/rlast lag %0d: got %0d/%0b expected %0d/%0b", tag,
                             lag, ridx, rlast, lag, lag == ORD);
                end
                if (lag == ORD) begin
                    checks++;
                    if (zc !== 9'(exp_zc)) begin
                        errors++;
                        $display("FAIL %s zc: got %0d expected %0d", tag, zc, exp_zc);
                    end
                    checks++;
                    if (voiced !== exp_voiced || z_voiced !== exp_voiced8 || busy !== 1'b1)
                    begin
                        errors++;
                        $display("FAIL %s voiced/voiced8/busy: got %0b/%0b/%0b expected %0b/%0b/1",
                                 tag, voiced, z_voiced, busy, exp_voiced, exp_voiced8);
                    end
                end
                lag++;
            end
        end
        if (lag < stop) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got lag %0d expected lag %0d", tag, lag, stop);
        end
        @(posedge clk);
        #1;
        rready = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || busy !== 1'(stop <= ORD)) begin
            errors++;
            $display("FAIL %s post-accept rvalid/busy: got %0b/%0b expected 0/%0b", tag,
                     rvalid, busy, stop <= ORD);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rout !== '0 || ridx !== '0 || zc !== '0) begin
            errors++;
            $display("FAIL reset data: got rout=%0d ridx=%0d zc=%0d expected 0", rout, ridx, zc);
        end
        checks++;
        if ({rvalid, rlast, voiced, busy, ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b expected 00000", {rvalid, rlast, voiced, busy, ovf});
        end
        do_reset();
    endtask

    task automatic test_const();
        drive_samples(FL, 0, 100);
        end_samples();
        compute_model(FL);
        check_frame("const", 0, ORD + 1, 1'b0);
    endtask

    task automatic test_alternating();
        drive_samples(FL, 1, 1000);
        end_samples();
        compute_model(FL);
        check_frame("alternating", 0, ORD + 1, 1'b0);
    endtask

    task automatic test_random();
        int amps [4];
        amps = '{32767, 3000, 40, 7};
        for (int k = 0; k < 8; k++) begin
            drive_samples(FL, 2, amps[k % 4]);
            end_samples();
            compute_model(FL);
            check_frame("random", 0, ORD + 1, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        int bad;
        int lat;
        logic signed [31:0] hold_r;
        logic [3:0] hold_i;
        drive_samples(FL, 2, 20000);
        end_samples();
        compute_model(FL);
        guard = 0;
        while (!rvalid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        hold_r = rout;
        hold_i = ridx;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rout !== hold_r || ridx !== hold_i || rvalid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (hold_r !== 32'(exp_r[0]) || hold_i !== 4'd0) begin
            errors++;
            $display("FAIL hold_value: got %0d idx %0d expected %0d idx 0", hold_r, hold_i,
                     exp_r[0]);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        lat = 0;
        while (!rvalid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat < (FL - 1) + 3 + 1 || lat > FL + 10) begin
            errors++;
            $display("FAIL next_lag_latency: got %0d expected >= %0d", lat, (FL - 1) + 3 + 1);
        end
        check_frame("backpressure", 1, ORD + 1, 1'b0);
    endtask

    task automatic test_overflow();
        int start;
        int late;
        rready = 1'b0;
        start = ovf_cnt;
        drive_samples(FL, 2, 30000);
        compute_model(FL);
        drive_samples(FL, 2, 30000);
        end_samples();
        repeat (3) @(negedge clk);
        checks++;
        if (ovf_cnt - start != 1) begin
            errors++;
            $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt - start);
        end
        check_frame("overflow", 0, ORD + 1, 1'b1);
        late = 0;
        rready = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (rvalid) late++;
        end
        rready = 1'b0;
        checks++;
        if (late != 0 || ovf_cnt - start != 1) begin
            errors++;
            $display("FAIL dropped_frame_output: got %0d rvalid cycles expected 0", late);
        end
    endtask

    task automatic test_reset_mid();
        drive_samples(FL, 2, 10000);
        end_samples();
        compute_model(FL);
        check_frame("pre_reset", 0, 4, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || busy !== 1'b0 || rout !== '0) begin
            errors++;
            $display("FAIL mid_reset: got rvalid=%0b busy=%0b rout=%0d expected 0/0/0", rvalid,
                     busy, rout);
        end
        do_reset();
        drive_samples(FL, 2, 25000);
        end_samples();
        compute_model(FL);
        check_frame("post_reset", 0, ORD + 1, 1'b1);
    endtask

    task automatic test_saturation();
        int guard;
        do_reset();
        drive_samples(256, 0, -32768);
        end_samples();
        compute_model(256);
        guard = 0;
        while (!b_rvalid && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (b_rvalid !== 1'b1 || b_rout !== 32'(exp_r[0]) || b_ridx !== 4'd0) begin
            errors++;
            $display("FAIL saturation_r0: got %0d (valid %0b idx %0d) expected %0d", b_rout,
                     b_rvalid, b_ridx, exp_r[0]);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_const();
        test_alternating();
        test_random();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
